// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage (M) and the debug loader (D).
// Latency: write ack 2 cycles after the request is sampled in IDLE, read ack 2+RD_LAT cycles after.
// Backpressure: requests are level-held until ack; M wins unless D has waited MAX_CONSEC M grants.
//
// Ports:
//   clk, rst                         clock and asynchronous active-high reset
//   m_req/m_we/m_addr/m_wdata/m_wstrb  MEM-stage request (byte address, bits [1:0] ignored)
//   m_rdata/m_ack                    MEM-stage completion pulse and read word
//   stall                            m_req & ~m_ack, freezes the pipeline front end
//   d_req/d_we/d_addr/d_wdata/d_wstrb  debug/loader request, same rules as M
//   d_rdata/d_ack                    debug completion pulse and read word
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  single-port memory interface
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int MAX_CONSEC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wdata,
    input  logic [3:0]        m_wstrb,
    output logic [31:0]       m_rdata,
    output logic              m_ack,
    output logic              stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic [31:0]       d_rdata,
    output logic              d_ack,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = $clog2(MAX_CONSEC + 1);
    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      consec_q, consec_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic               sel_d_q, sel_d_d;   // 1: current access belongs to D
    logic               we_q, we_d;
    logic               mem_en_q, mem_en_d;
    logic [3:0]         mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               m_ack_q, m_ack_d;
    logic               d_ack_q, d_ack_d;
    logic [31:0]        m_rdata_q, m_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               grant_m, grant_d;

    // Byte-offset and out-of-range address bits are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m_addr[31:ADDR_W+2], m_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Arbitration only happens in IDLE; D is forced through once M has
    // taken MAX_CONSEC grants back-to-back while D was waiting.
    always_comb begin
        grant_m = 1'b0;
        grant_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (d_req && (consec_q == CW'(MAX_CONSEC))) begin
                grant_d = 1'b1;
            end else if (m_req) begin
                grant_m = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            consec_q    <= '0;
            lat_q       <= '0;
            sel_d_q     <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            m_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            consec_q    <= consec_d;
            lat_q       <= lat_d;
            sel_d_q     <= sel_d_d;
            we_q        <= we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m_ack_q     <= m_ack_d;
            d_ack_q     <= d_ack_d;
            m_rdata_q   <= m_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state logic; lat_q counts the read-latency cycles spent in WAIT.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (grant_m || grant_d) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                lat_d   = '0;
                state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LW'(RD_LAT - 1)) begin
                    state_d = S_DONE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic. Request fields are latched only on a grant,
    // so they stay stable from ACCESS through DONE whatever the inputs do.
    always_comb begin
        consec_d    = consec_q;
        sel_d_d     = sel_d_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        m_rdata_d   = '0;
        d_rdata_d   = '0;

        if (grant_m) begin
            sel_d_d     = 1'b0;
            we_d        = m_we;
            mem_en_d    = 1'b1;
            mem_we_d    = m_we ? m_wstrb : 4'h0;
            mem_addr_d  = m_addr[ADDR_W+1:2];
            mem_wdata_d = m_wdata;
            if (!d_req) begin
                consec_d = '0;
            end else if (consec_q != CW'(MAX_CONSEC)) begin
                consec_d = consec_q + CW'(1);
            end
        end

        if (grant_d) begin
            sel_d_d     = 1'b1;
            we_d        = d_we;
            mem_en_d    = 1'b1;
            mem_we_d    = d_we ? d_wstrb : 4'h0;
            mem_addr_d  = d_addr[ADDR_W+1:2];
            mem_wdata_d = d_wdata;
            consec_d    = '0;
        end

        // Entering DONE: pulse the winner's ack. Only the last WAIT edge
        // carries valid read data; writes return zero.
        if (state_d == S_DONE) begin
            m_ack_d = ~sel_d_q;
            d_ack_d = sel_d_q;
            if (state_q == S_WAIT) begin
                if (sel_d_q) begin
                    d_rdata_d = mem_rdata;
                end else begin
                    m_rdata_d = mem_rdata;
                end
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign m_ack     = m_ack_q;
    assign d_ack     = d_ack_q;
    assign m_rdata   = m_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = m_req & ~m_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [9:0]  exp_maddr;
        logic [3:0]  exp_mwe;
        int          exp_lat;
        logic [31:0] exp_rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // DUT with RD_LAT=1
    logic        m_req = 0, m_we = 0, d_req = 0, d_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [3:0]  m_wstrb = 0, d_wstrb = 0;
    logic [31:0] m_rdata, d_rdata, mem_wdata, mem_rdata;
    logic        m_ack, d_ack, stall, mem_en;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;

    dmem_arbiter #(.ADDR_W(10), .RD_LAT(1), .MAX_CONSEC(4)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_ack(m_ack), .stall(stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Byte-lane memory, one-cycle read latency
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            mem[16] <= 32'h5555AAAA;
            rd_q    <= '0;
        end else if (mem_en) begin
            rd_q <= mem[mem_addr];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = rd_q;

    // DUT with RD_LAT=3, M port only
    logic        t3_m_req = 0, t3_m_we = 0;
    logic [31:0] t3_m_addr = 0;
    logic [31:0] t3_m_rdata, t3_d_rdata, t3_mem_wdata, t3_mem_rdata;
    logic        t3_m_ack, t3_d_ack, t3_stall, t3_mem_en;
    logic [3:0]  t3_mem_we;
    logic [9:0]  t3_mem_addr;

    dmem_arbiter #(.ADDR_W(10), .RD_LAT(3), .MAX_CONSEC(4)) dut3 (
        .clk(clk), .rst(rst),
        .m_req(t3_m_req), .m_we(t3_m_we), .m_addr(t3_m_addr), .m_wdata(32'h0), .m_wstrb(4'h0),
        .m_rdata(t3_m_rdata), .m_ack(t3_m_ack), .stall(t3_stall),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_wstrb(4'h0),
        .d_rdata(t3_d_rdata), .d_ack(t3_d_ack),
        .mem_en(t3_mem_en), .mem_we(t3_mem_we), .mem_addr(t3_mem_addr), .mem_wdata(t3_mem_wdata),
        .mem_rdata(t3_mem_rdata)
    );

    // Read data is a tag of the address, valid only exactly 3 cycles after mem_en
    logic [31:0] p3_0, p3_1, p3_2;
    always @(posedge clk) begin
        p3_0 <= t3_mem_en ? (32'hC0DE0000 | {22'b0, t3_mem_addr}) : 32'h0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign t3_mem_rdata = p3_2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
        end
    endtask

    // One isolated request on dut; checks memory strobe, latency, ack routing, data and stall.
    task automatic run_txn(input txn_t t, input int idx);
        int n0;
        bit got;
        int n_en;
        @(posedge clk); #1;
        if (t.is_d) begin
            d_req = 1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_wstrb = t.wstrb;
        end else begin
            m_req = 1; m_we = t.we; m_addr = t.addr; m_wdata = t.wdata; m_wstrb = t.wstrb;
        end
        n0 = cyc; got = 0; n_en = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (mem_en) begin
                n_en++;
                chk($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(t.exp_maddr));
                chk($sformatf("v%0d_mem_we", idx), 32'(mem_we), 32'(t.exp_mwe));
                if (t.we) chk($sformatf("v%0d_mem_wdata", idx), mem_wdata, t.wdata);
            end
            if (m_ack || d_ack) begin
                got = 1;
                chk($sformatf("v%0d_latency", idx), 32'(cyc - n0), 32'(t.exp_lat));
                chk($sformatf("v%0d_winner_ack", idx), 32'(t.is_d ? d_ack : m_ack), 32'd1);
                chk($sformatf("v%0d_other_ack", idx), 32'(t.is_d ? m_ack : d_ack), 32'd0);
                chk($sformatf("v%0d_rdata", idx), t.is_d ? d_rdata : m_rdata, t.exp_rdata);
                chk($sformatf("v%0d_other_rdata", idx), t.is_d ? m_rdata : d_rdata, 32'd0);
            end
            chk($sformatf("v%0d_stall", idx), 32'(stall), (!t.is_d && !got) ? 32'd1 : 32'd0);
        end
        if (!got) chk($sformatf("v%0d_ack_timeout", idx), 32'd0, 32'd1);
        chk($sformatf("v%0d_mem_en_cycles", idx), 32'(n_en), 32'd1);
        @(posedge clk); #1;
        m_req = 0; d_req = 0;
    endtask

    txn_t vec [10];
    logic exp_g [11];
    logic got_g [11];

    initial begin
        int n0, mc, dc, n_ack, acks;
        bit got;

        vec[0] = '{1'b0, 1'b1, 32'h00000020, 32'hABCD1234, 4'hF, 10'h008, 4'hF, 2, 32'h0};
        vec[1] = '{1'b0, 1'b0, 32'h00000020, 32'hDEADBEEF, 4'hF, 10'h008, 4'h0, 3, 32'hABCD1234};
        vec[2] = '{1'b0, 1'b1, 32'h00000020, 32'h0000EF00, 4'h2, 10'h008, 4'h2, 2, 32'h0};
        vec[3] = '{1'b0, 1'b0, 32'h00000020, 32'hDEADBEEF, 4'hF, 10'h008, 4'h0, 3, 32'hABCDEF34};
        vec[4] = '{1'b1, 1'b1, 32'h00000044, 32'h12345678, 4'hF, 10'h011, 4'hF, 2, 32'h0};
        vec[5] = '{1'b1, 1'b0, 32'h00000044, 32'hDEADBEEF, 4'hF, 10'h011, 4'h0, 3, 32'h12345678};
        vec[6] = '{1'b0, 1'b1, 32'h00000047, 32'hFFFFFFFF, 4'h0, 10'h011, 4'h0, 2, 32'h0};
        vec[7] = '{1'b0, 1'b0, 32'h00000044, 32'hDEADBEEF, 4'hF, 10'h011, 4'h0, 3, 32'h12345678};
        vec[8] = '{1'b1, 1'b1, 32'h12345FFC, 32'hCAFEF00D, 4'hF, 10'h3FF, 4'hF, 2, 32'h0};
        vec[9] = '{1'b0, 1'b0, 32'h00000FFC, 32'hDEADBEEF, 4'hF, 10'h3FF, 4'h0, 3, 32'hCAFEF00D};
        exp_g = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks", {30'b0, m_ack, d_ack}, 0);
        chk("rst_rdata", m_rdata | d_rdata, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_t3_mem_en", 32'(t3_mem_en), 0);
        rst = 0;

        // Reset asserted mid-read (dut3 in WAIT): everything clears, no ack afterwards
        @(posedge clk); #1;
        t3_m_req = 1; t3_m_we = 0; t3_m_addr = 32'h80;
        @(posedge clk); @(posedge clk); #1;
        chk("midrd_latched_addr", 32'(t3_mem_addr), 32'h20);
        rst = 1;
        #1;
        chk("midrd_mem_en", 32'(t3_mem_en), 0);
        chk("midrd_mem_we", 32'(t3_mem_we), 0);
        chk("midrd_mem_addr", 32'(t3_mem_addr), 0);
        chk("midrd_mem_wdata", t3_mem_wdata, 0);
        chk("midrd_acks", {30'b0, t3_m_ack, t3_d_ack}, 0);
        chk("midrd_rdata", t3_m_rdata | t3_d_rdata, 0);
        t3_m_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (t3_m_ack || t3_d_ack) acks++;
        end
        chk("midrd_no_ack_after_release", 32'(acks), 0);

        // RD_LAT=3 read: ack at N+5 with the word returned 3 cycles after mem_en
        @(posedge clk); #1;
        t3_m_req = 1; t3_m_we = 0; t3_m_addr = 32'h80;
        n0 = cyc; got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (t3_m_ack) begin
                got = 1;
                chk("lat3_latency", 32'(cyc - n0), 32'd5);
                chk("lat3_rdata", t3_m_rdata, 32'hC0DE0020);
            end
        end
        if (!got) chk("lat3_ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        t3_m_req = 0;

        // Single-requester vectors
        for (int i = 0; i < 10; i++) run_txn(vec[i], i);

        // Same-cycle D write and M read to 0x40: M first sees old data
        @(posedge clk); #1;
        m_req = 1; m_we = 0; m_addr = 32'h40;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h0BADCAFE; d_wstrb = 4'hF;
        n0 = cyc; mc = -1; dc = -1;
        for (int k = 0; k < 30 && (mc < 0 || dc < 0); k++) begin
            @(negedge clk);
            if (m_ack) begin
                mc = cyc - n0;
                chk("race_m_rdata_old", m_rdata, 32'h5555AAAA);
                chk("race_d_ack_quiet", 32'(d_ack), 0);
            end
            if (d_ack) begin
                dc = cyc - n0;
                chk("race_d_rdata_zero", d_rdata, 0);
            end
            @(posedge clk); #1;
            if (mc >= 0) m_req = 0;
            if (dc >= 0) d_req = 0;
        end
        chk("race_m_latency", 32'(mc), 32'd3);
        chk("race_d_latency", 32'(dc), 32'd6);
        run_txn('{1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 10'h010, 4'h0, 3, 32'h0BADCAFE}, 10);

        // Both requesters held: M x4 then D, counter restarts after D
        @(posedge clk); #1;
        m_req = 1; m_we = 0; m_addr = 32'h20;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        n_ack = 0;
        for (int k = 0; k < 80 && n_ack < 11; k++) begin
            @(negedge clk);
            chk("arb_stall", 32'(stall), m_ack ? 32'd0 : 32'd1);
            if (m_ack && d_ack) chk("arb_dual_ack", 32'd1, 32'd0);
            if (m_ack) begin got_g[n_ack] = 1'b0; n_ack++; end
            else if (d_ack) begin got_g[n_ack] = 1'b1; n_ack++; end
        end
        chk("arb_ack_count", 32'(n_ack), 32'd11);
        for (int i = 0; i < n_ack; i++)
            chk($sformatf("arb_grant%0d_is_d", i), 32'(got_g[i]), 32'(exp_g[i]));
        @(posedge clk); #1;
        m_req = 0; d_req = 0;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
